// File: rtl/fetch_sched.sv
// Fetch scheduler: branch-wait / redirect / GPU-stall FSM driving fetch stall and redirect controls.
// All outputs registered; one-cycle latency from inputs. No backpressure; inputs sampled every cycle.
module fetch_sched #(
    parameter int PC_WIDTH      = 16,
    parameter int GPU_CNT_WIDTH = 4,
    parameter int BR_TIMEOUT    = 8
) (
    input  logic                I_CLOCK,
    input  logic                I_RESET,
    input  logic                I_BranchDecoded,
    input  logic                I_BranchResolved,
    input  logic                I_BranchTaken,
    input  logic [PC_WIDTH-1:0] I_BranchTarget,
    input  logic                I_DepHazard,
    input  logic                I_GPUReq,
    input  logic [GPU_CNT_WIDTH-1:0] I_GPUCycles,
    output logic                O_BranchStallSignal,
    output logic                O_DepStallSignal,
    output logic                O_GPUStallSignal,
    output logic                O_BranchAddrSelect,
    output logic [PC_WIDTH-1:0] O_BranchPC,
    output logic [1:0]          O_State,
    output logic [15:0]         O_StallCount,
    output logic                O_Timeout
);

    typedef enum logic [1:0] {
        RUN       = 2'd0,
        BR_WAIT   = 2'd1,
        REDIRECT  = 2'd2,
        GPU_STALL = 2'd3
    } state_t;

    localparam logic [7:0] BR_LAST = 8'(BR_TIMEOUT - 1);

    state_t                    r_state;
    logic [7:0]                r_br_cnt;
    logic [GPU_CNT_WIDTH-1:0]  r_gpu_cnt;
    logic                      r_pending;
    logic                      r_bstall;
    logic                      r_dstall;
    logic                      r_gstall;
    logic                      r_addr_sel;
    logic [PC_WIDTH-1:0]       r_pc;
    logic [15:0]               r_stall_cnt;
    logic                      r_timeout;

    state_t                    w_state_nxt;
    logic [7:0]                w_br_cnt_nxt;
    logic [GPU_CNT_WIDTH-1:0]  w_gpu_cnt_nxt;
    logic                      w_pending_nxt;
    logic [PC_WIDTH-1:0]       w_pc_nxt;
    logic                      w_timeout_nxt;
    logic                      w_any_stall;

    always_comb begin
        w_state_nxt   = r_state;
        w_br_cnt_nxt  = r_br_cnt;
        w_gpu_cnt_nxt = r_gpu_cnt;
        w_pending_nxt = r_pending;
        w_pc_nxt      = r_pc;
        w_timeout_nxt = r_timeout;
        case (r_state)
            RUN: begin
                if (I_GPUReq) begin
                    w_state_nxt   = GPU_STALL;
                    w_gpu_cnt_nxt = (I_GPUCycles == '0) ? GPU_CNT_WIDTH'(1) : I_GPUCycles;
                    w_pending_nxt = I_BranchDecoded;
                end else if (I_BranchDecoded) begin
                    w_state_nxt  = BR_WAIT;
                    w_br_cnt_nxt = '0;
                end
            end
            BR_WAIT: begin
                w_br_cnt_nxt = r_br_cnt + 8'd1;
                // Resolution on the final wait cycle takes precedence over timeout.
                if (I_BranchResolved && I_BranchTaken) begin
                    w_pc_nxt    = I_BranchTarget;
                    w_state_nxt = REDIRECT;
                end else if (I_BranchResolved) begin
                    w_state_nxt = RUN;
                end else if (r_br_cnt >= BR_LAST) begin
                    w_state_nxt   = RUN;
                    w_timeout_nxt = 1'b1;
                end
            end
            REDIRECT: begin
                w_state_nxt = RUN;
            end
            GPU_STALL: begin
                w_gpu_cnt_nxt = r_gpu_cnt - GPU_CNT_WIDTH'(1);
                if (r_gpu_cnt <= GPU_CNT_WIDTH'(1)) begin
                    w_gpu_cnt_nxt = '0;
                    if (r_pending) begin
                        w_state_nxt   = BR_WAIT;
                        w_br_cnt_nxt  = '0;
                        w_pending_nxt = 1'b0;
                    end else begin
                        w_state_nxt = RUN;
                    end
                end
            end
            default: w_state_nxt = RUN;
        endcase
    end

    assign w_any_stall = r_bstall | r_dstall | r_gstall;

    always_ff @(posedge I_CLOCK) begin
        if (I_RESET) begin
            r_state     <= RUN;
            r_br_cnt    <= '0;
            r_gpu_cnt   <= '0;
            r_pending   <= 1'b0;
            r_bstall    <= 1'b0;
            r_dstall    <= 1'b0;
            r_gstall    <= 1'b0;
            r_addr_sel  <= 1'b0;
            r_pc        <= '0;
            r_stall_cnt <= '0;
            r_timeout   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_br_cnt   <= w_br_cnt_nxt;
            r_gpu_cnt  <= w_gpu_cnt_nxt;
            r_pending  <= w_pending_nxt;
            r_pc       <= w_pc_nxt;
            r_timeout  <= w_timeout_nxt;
            // Outputs decode the next state so they line up with O_State.
            r_bstall   <= (w_state_nxt == BR_WAIT) || (w_state_nxt == GPU_STALL);
            r_gstall   <= (w_state_nxt == GPU_STALL);
            r_addr_sel <= (w_state_nxt == REDIRECT);
            r_dstall   <= I_DepHazard && (w_state_nxt != REDIRECT);
            if (w_any_stall && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
        end
    end

    assign O_BranchStallSignal = r_bstall;
    assign O_DepStallSignal    = r_dstall;
    assign O_GPUStallSignal    = r_gstall;
    assign O_BranchAddrSelect  = r_addr_sel;
    assign O_BranchPC          = r_pc;
    assign O_State             = r_state;
    assign O_StallCount        = r_stall_cnt;
    assign O_Timeout           = r_timeout;

endmodule

// File: tb/tb_fetch_sched.sv
// Directed testbench for fetch_sched with immediate-assertion checks after each clock edge.
module tb_fetch_sched;

    logic        I_CLOCK = 1'b0;
    logic        I_RESET;
    logic        I_BranchDecoded;
    logic        I_BranchResolved;
    logic        I_BranchTaken;
    logic [15:0] I_BranchTarget;
    logic        I_DepHazard;
    logic        I_GPUReq;
    logic [3:0]  I_GPUCycles;
    logic        O_BranchStallSignal;
    logic        O_DepStallSignal;
    logic        O_GPUStallSignal;
    logic        O_BranchAddrSelect;
    logic [15:0] O_BranchPC;
    logic [1:0]  O_State;
    logic [15:0] O_StallCount;
    logic        O_Timeout;

    int checks = 0;
    int errors = 0;

    fetch_sched #(.PC_WIDTH(16), .GPU_CNT_WIDTH(4), .BR_TIMEOUT(8)) dut (
        .I_CLOCK            (I_CLOCK),
        .I_RESET            (I_RESET),
        .I_BranchDecoded    (I_BranchDecoded),
        .I_BranchResolved   (I_BranchResolved),
        .I_BranchTaken      (I_BranchTaken),
        .I_BranchTarget     (I_BranchTarget),
        .I_DepHazard        (I_DepHazard),
        .I_GPUReq           (I_GPUReq),
        .I_GPUCycles        (I_GPUCycles),
        .O_BranchStallSignal(O_BranchStallSignal),
        .O_DepStallSignal   (O_DepStallSignal),
        .O_GPUStallSignal   (O_GPUStallSignal),
        .O_BranchAddrSelect (O_BranchAddrSelect),
        .O_BranchPC         (O_BranchPC),
        .O_State            (O_State),
        .O_StallCount       (O_StallCount),
        .O_Timeout          (O_Timeout)
    );

    always #5 I_CLOCK = ~I_CLOCK;

    task automatic tick();
        @(posedge I_CLOCK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Packed as {state, branch_stall, dep_stall, gpu_stall, addr_sel}.
    task automatic chk_o(input string tag, input logic [1:0] st, input logic bs,
                         input logic ds, input logic gs, input logic as_);
        chk(tag, {26'd0, O_State, O_BranchStallSignal, O_DepStallSignal, O_GPUStallSignal, O_BranchAddrSelect},
                 {26'd0, st, bs, ds, gs, as_});
    endtask

    task automatic clr_in();
        I_BranchDecoded  = 1'b0;
        I_BranchResolved = 1'b0;
        I_BranchTaken    = 1'b0;
        I_BranchTarget   = 16'h0000;
        I_DepHazard      = 1'b0;
        I_GPUReq         = 1'b0;
        I_GPUCycles      = 4'd0;
    endtask

    initial begin
        clr_in();
        I_RESET = 1'b1;
        tick();
        tick();
        chk_o("reset_outs", 2'd0, 0, 0, 0, 0);
        chk("reset_pc", 32'(O_BranchPC), 32'h0);
        chk("reset_cnt", 32'(O_StallCount), 32'h0);
        chk("reset_to", 32'(O_Timeout), 32'h0);
        I_RESET = 1'b0;

        // Taken branch resolved after three stall cycles.
        I_BranchDecoded = 1'b1;
        tick();
        chk_o("tk_w1", 2'd1, 1, 0, 0, 0);
        clr_in();
        tick();
        chk_o("tk_w2", 2'd1, 1, 0, 0, 0);
        tick();
        chk_o("tk_w3", 2'd1, 1, 0, 0, 0);
        I_BranchResolved = 1'b1; I_BranchTaken = 1'b1; I_BranchTarget = 16'h0040;
        tick();
        chk_o("tk_redir", 2'd2, 0, 0, 0, 1);
        chk("tk_pc", 32'(O_BranchPC), 32'h0040);
        clr_in();
        tick();
        chk_o("tk_run", 2'd0, 0, 0, 0, 0);
        chk("tk_cnt", 32'(O_StallCount), 32'd3);

        // Not-taken branch after two stall cycles.
        I_BranchDecoded = 1'b1;
        tick();
        chk_o("nt_w1", 2'd1, 1, 0, 0, 0);
        clr_in();
        tick();
        chk_o("nt_w2", 2'd1, 1, 0, 0, 0);
        I_BranchResolved = 1'b1; I_BranchTaken = 1'b0; I_BranchTarget = 16'h1234;
        tick();
        chk_o("nt_run", 2'd0, 0, 0, 0, 0);
        chk("nt_pc", 32'(O_BranchPC), 32'h0040);
        chk("nt_cnt", 32'(O_StallCount), 32'd5);

        // GPU stall with a branch decoded the same cycle.
        clr_in();
        I_GPUReq = 1'b1; I_GPUCycles = 4'd3; I_BranchDecoded = 1'b1;
        tick();
        chk_o("gpu_1", 2'd3, 1, 0, 1, 0);
        clr_in();
        I_GPUReq = 1'b1; I_GPUCycles = 4'd9;
        tick();
        chk_o("gpu_2", 2'd3, 1, 0, 1, 0);
        clr_in();
        tick();
        chk_o("gpu_3", 2'd3, 1, 0, 1, 0);
        tick();
        chk_o("gpu_brw", 2'd1, 1, 0, 0, 0);
        I_BranchResolved = 1'b1;
        tick();
        chk_o("gpu_run", 2'd0, 0, 0, 0, 0);
        chk("gpu_cnt", 32'(O_StallCount), 32'd9);

        // Zero-length GPU request acts as a single stall cycle.
        clr_in();
        I_GPUReq = 1'b1; I_GPUCycles = 4'd0;
        tick();
        chk_o("gpu0_1", 2'd3, 1, 0, 1, 0);
        clr_in();
        tick();
        chk_o("gpu0_run", 2'd0, 0, 0, 0, 0);
        chk("gpu0_cnt", 32'(O_StallCount), 32'd10);

        // Unresolved branch times out after eight stall cycles.
        I_BranchDecoded = 1'b1;
        tick();
        clr_in();
        for (int i = 0; i < 7; i++) begin
            chk_o("to_wait", 2'd1, 1, 0, 0, 0);
            tick();
        end
        chk_o("to_wait8", 2'd1, 1, 0, 0, 0);
        chk("to_not_yet", 32'(O_Timeout), 32'h0);
        tick();
        chk_o("to_run", 2'd0, 0, 0, 0, 0);
        chk("to_flag", 32'(O_Timeout), 32'h1);
        chk("to_cnt", 32'(O_StallCount), 32'd18);
        tick();
        chk("to_sticky", 32'(O_Timeout), 32'h1);

        // Resolution on the eighth stall cycle beats the timeout.
        I_RESET = 1'b1;
        tick();
        chk("rst_to", 32'(O_Timeout), 32'h0);
        I_RESET = 1'b0;
        I_BranchDecoded = 1'b1;
        tick();
        clr_in();
        for (int i = 0; i < 7; i++) tick();
        chk_o("late_w8", 2'd1, 1, 0, 0, 0);
        I_BranchResolved = 1'b1; I_BranchTaken = 1'b1; I_BranchTarget = 16'hBEEF;
        tick();
        chk_o("late_redir", 2'd2, 0, 0, 0, 1);
        chk("late_pc", 32'(O_BranchPC), 32'hBEEF);
        chk("late_no_to", 32'(O_Timeout), 32'h0);
        clr_in();
        tick();
        chk("late_cnt", 32'(O_StallCount), 32'd8);

        // Dependency hazard for five cycles spanning a redirect.
        I_BranchDecoded = 1'b1; I_DepHazard = 1'b1;
        tick();
        chk_o("dep_1", 2'd1, 1, 1, 0, 0);
        I_BranchDecoded = 1'b0;
        tick();
        chk_o("dep_2", 2'd1, 1, 1, 0, 0);
        I_BranchResolved = 1'b1; I_BranchTaken = 1'b1; I_BranchTarget = 16'h0ABC;
        tick();
        chk_o("dep_redir", 2'd2, 0, 0, 0, 1);
        I_BranchResolved = 1'b0; I_BranchTaken = 1'b0;
        tick();
        chk_o("dep_4", 2'd0, 0, 1, 0, 0);
        tick();
        chk_o("dep_5", 2'd0, 0, 1, 0, 0);
        I_DepHazard = 1'b0;
        tick();
        chk_o("dep_off", 2'd0, 0, 0, 0, 0);
        chk("dep_cnt", 32'(O_StallCount), 32'd12);

        // Reset in the middle of a GPU stall.
        clr_in();
        I_GPUReq = 1'b1; I_GPUCycles = 4'd5;
        tick();
        chk_o("mgpu_in", 2'd3, 1, 0, 1, 0);
        clr_in();
        I_RESET = 1'b1; I_DepHazard = 1'b1; I_BranchDecoded = 1'b1; I_GPUReq = 1'b1;
        tick();
        chk_o("mgpu_rst", 2'd0, 0, 0, 0, 0);
        chk("mgpu_pc", 32'(O_BranchPC), 32'h0);
        chk("mgpu_cnt", 32'(O_StallCount), 32'h0);

        // Reset in the middle of a branch wait, with a taken resolution present.
        clr_in();
        I_RESET = 1'b0;
        I_BranchDecoded = 1'b1;
        tick();
        chk_o("mbr_in", 2'd1, 1, 0, 0, 0);
        clr_in();
        I_RESET = 1'b1; I_BranchResolved = 1'b1; I_BranchTaken = 1'b1; I_BranchTarget = 16'h5555;
        tick();
        chk_o("mbr_rst", 2'd0, 0, 0, 0, 0);
        chk("mbr_pc", 32'(O_BranchPC), 32'h0);
        chk("mbr_cnt", 32'(O_StallCount), 32'h0);
        clr_in();
        I_RESET = 1'b0;
        tick();
        chk_o("post_rst", 2'd0, 0, 0, 0, 0);

        // Stall counter saturation.
        I_DepHazard = 1'b1;
        tick();
        repeat (65534) tick();
        chk("sat_fffe", 32'(O_StallCount), 32'hFFFE);
        tick();
        chk("sat_ffff", 32'(O_StallCount), 32'hFFFF);
        tick();
        tick();
        chk("sat_hold", 32'(O_StallCount), 32'hFFFF);
        clr_in();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
